// File: rtl/dsp_add8_arbiter.sv
// Round-robin arbiter time-sharing one pipelined 8-operand adder among NUM_REQ requesters.
// A tag pipe steers each sum back to its owner; a flush/drain FSM empties the pipe at frame ends.
module dsp_add8_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*144-1:0]   req_op,
  input  logic [NUM_REQ*4-1:0]     req_cin,
  output logic [143:0]             dsp_op,
  output logic [3:0]               dsp_cin,
  output logic                     dsp_reset,
  input  logic [47:0]              dsp_result,
  output logic [NUM_REQ-1:0]       res_valid,
  output logic [47:0]              res_data,
  input  logic                     flush,
  output logic                     flush_done,
  output logic                     busy
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned OP_W   = 144;
  localparam int unsigned CIN_W  = 4;
  localparam int unsigned STAGES = LATENCY + 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   grant_idx;
  logic               xfer;
  logic [STAGES-1:0]  tag_valid;
  logic [IDX_W-1:0]   tag_idx [STAGES];

  // Round-robin search starting after the last granted requester
  always_comb begin
    xfer      = 1'b0;
    grant_idx = '0;
    cand      = '0;
    req_ready = '0;
    if (aresetn && state == RUN && !flush) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
        if (!xfer && req_valid[cand]) begin
          xfer      = 1'b1;
          grant_idx = cand;
        end
      end
      if (xfer) req_ready[grant_idx] = 1'b1;
    end
  end

  // Flush sequencing
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush) state_next = DRAIN;
      DRAIN:   if (!flush) state_next = RUN;
               else if (!busy) state_next = DONE;
      DONE:    if (!flush) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= RUN;
      ptr        <= IDX_W'(NUM_REQ - 1);
      dsp_op     <= '0;
      dsp_cin    <= '0;
      dsp_reset  <= 1'b1;
      tag_valid  <= '0;
      res_valid  <= '0;
      res_data   <= '0;
      flush_done <= 1'b0;
      busy       <= 1'b0;
      for (int unsigned s = 0; s < STAGES; s++) tag_idx[s] <= '0;
    end else begin
      state      <= state_next;
      flush_done <= (state_next == DONE);
      dsp_reset  <= !xfer;
      if (xfer) begin
        ptr     <= grant_idx;
        dsp_op  <= req_op[OP_W*grant_idx +: OP_W];
        dsp_cin <= req_cin[CIN_W*grant_idx +: CIN_W];
      end
      // Stage 0 tracks dsp_op; the last stage lines up with dsp_result
      tag_valid  <= {tag_valid[STAGES-2:0], xfer};
      tag_idx[0] <= grant_idx;
      for (int unsigned s = 1; s < STAGES; s++) tag_idx[s] <= tag_idx[s-1];
      busy <= xfer | (|tag_valid[STAGES-2:0]);
      res_valid <= tag_valid[STAGES-1] ? (NUM_REQ'(1) << tag_idx[STAGES-1]) : '0;
      if (tag_valid[STAGES-1]) res_data <= dsp_result;
    end
  end

endmodule

// File: tb/tb_dsp_add8_arbiter.sv
// Bench for dsp_add8_arbiter: behavioural adder, per-cycle reference model and directed checks.
module tb_dsp_add8_arbiter;
  localparam int NR   = 2;
  localparam int LAT  = 4;
  localparam int MAXC = 8192;
  localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;

  logic               clk = 1'b0;
  logic               aresetn;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [NR*144-1:0]  req_op;
  logic [NR*4-1:0]    req_cin;
  logic [143:0]       dsp_op;
  logic [3:0]         dsp_cin;
  logic               dsp_reset;
  logic [47:0]        dsp_result;
  logic [NR-1:0]      res_valid;
  logic [47:0]        res_data;
  logic               flush;
  logic               flush_done;
  logic               busy;

  dsp_add8_arbiter #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
    .clk(clk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_cin(req_cin), .dsp_op(dsp_op), .dsp_cin(dsp_cin),
    .dsp_reset(dsp_reset), .dsp_result(dsp_result), .res_valid(res_valid),
    .res_data(res_data), .flush(flush), .flush_done(flush_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [143:0] got, input logic [143:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Exact signed sum of eight s18 operands plus the carry-in bits
  function automatic logic [47:0] add8(input logic [143:0] op, input logic [3:0] cin);
    longint s;
    logic [17:0] f;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      f = op[i*18 +: 18];
      s += longint'($signed(f));
    end
    for (int j = 0; j < 4; j++) s += longint'(cin[j]);
    return 48'(s);
  endfunction

  // Attached adder: LAT-cycle pipeline
  logic [47:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= add8(dsp_op, dsp_cin);
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign dsp_result = apipe[LAT-1];

  // Reference model state
  typedef struct { int due; int idx; logic [47:0] sum; } exp_t;
  exp_t          pq[$];
  exp_t          e;
  int            ncyc = 0;
  int            m_ptr, m_mode, g, cidx, cn;
  logic          m_fd, m_dr, m_busy;
  logic [143:0]  m_op;
  logic [3:0]    m_cin;
  logic [47:0]   m_rd;
  logic [NR-1:0] exp_rv, exp_rr;

  logic [NR-1:0] rv_log [MAXC];
  logic [NR-1:0] rr_log [MAXC];
  logic          dr_log [MAXC];
  logic          fd_log [MAXC];
  logic [47:0]   rd_log [MAXC];

  // Per-cycle compare against the model
  always @(negedge clk) begin
    cn = ncyc;
    if (cn < MAXC) begin
      rv_log[cn] = res_valid; rr_log[cn] = req_ready; dr_log[cn] = dsp_reset;
      fd_log[cn] = flush_done; rd_log[cn] = res_data;
    end
    if (!aresetn) begin
      chk("rst_req_ready", 144'(req_ready), 144'(0));
      chk("rst_dsp_op", dsp_op, 144'(0));
      chk("rst_dsp_cin", 144'(dsp_cin), 144'(0));
      chk("rst_dsp_reset", 144'(dsp_reset), 144'(1));
      chk("rst_res_valid", 144'(res_valid), 144'(0));
      chk("rst_res_data", 144'(res_data), 144'(0));
      chk("rst_flush_done", 144'(flush_done), 144'(0));
      chk("rst_busy", 144'(busy), 144'(0));
      pq.delete();
      m_ptr = NR - 1; m_mode = M_RUN; m_fd = 1'b0; m_dr = 1'b1;
      m_op = '0; m_cin = '0; m_rd = '0;
    end else begin
      exp_rv = '0;
      if (pq.size() > 0 && pq[0].due == cn) begin
        exp_rv = NR'(1) << pq[0].idx;
        m_rd   = pq[0].sum;
        void'(pq.pop_front());
      end
      m_busy = (pq.size() != 0);
      chk("res_valid", 144'(res_valid), 144'(exp_rv));
      chk("res_data", 144'(res_data), 144'(m_rd));
      chk("busy", 144'(busy), 144'(m_busy));
      chk("flush_done", 144'(flush_done), 144'(m_fd));
      chk("dsp_reset", 144'(dsp_reset), 144'(m_dr));
      chk("dsp_op", dsp_op, m_op);
      chk("dsp_cin", 144'(dsp_cin), 144'(m_cin));
      g = -1;
      if (m_mode == M_RUN && !flush)
        for (int k = 1; k <= NR; k++) begin
          cidx = (m_ptr + k) % NR;
          if (g < 0 && req_valid[cidx]) g = cidx;
        end
      exp_rr = (g >= 0) ? (NR'(1) << g) : '0;
      chk("req_ready", 144'(req_ready), 144'(exp_rr));
      if (g >= 0) begin
        m_ptr = g;
        m_op  = req_op[g*144 +: 144];
        m_cin = req_cin[g*4 +: 4];
        e.due = cn + LAT + 2; e.idx = g; e.sum = add8(m_op, m_cin);
        pq.push_back(e);
        m_dr = 1'b0;
      end else begin
        m_dr = 1'b1;
      end
      case (m_mode)
        M_RUN:   if (flush) m_mode = M_DRAIN;
        M_DRAIN: if (!flush) m_mode = M_RUN; else if (!m_busy) m_mode = M_DONE;
        default: if (!flush) m_mode = M_RUN;
      endcase
      m_fd = (m_mode == M_DONE);
    end
    ncyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic set_op(input int r, input logic [17:0] v, input logic [3:0] c);
    for (int i = 0; i < 8; i++) req_op[r*144 + i*18 +: 18] = v;
    req_cin[r*4 +: 4] = c;
  endtask

  task automatic rand_ops();
    logic [17:0] v;
    for (int r = 0; r < NR; r++) begin
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 5))
          0:       v = 18'h1FFFF;
          1:       v = 18'h20000;
          2:       v = 18'h3FFFF;
          default: v = 18'($urandom);
        endcase
        req_op[r*144 + i*18 +: 18] = v;
      end
      req_cin[r*4 +: 4] = 4'($urandom);
    end
  endtask

  int n0;

  initial begin
    aresetn = 1'b0; req_valid = '0; req_op = '0; req_cin = '0; flush = 1'b0;
    ticks(3);
    aresetn = 1'b1;
    ticks(4);

    // single op from req0
    n0 = ncyc; set_op(0, 18'd100, 4'b1111); req_valid = 2'b01;
    tick(); req_valid = '0;
    ticks(12);
    chk("t1_ready", 144'(rr_log[n0]), 144'(2'b01));
    chk("t1_issue", 144'(dr_log[n0+1]), 144'(0));
    chk("t1_early", 144'(rv_log[n0+5]), 144'(0));
    chk("t1_valid", 144'(rv_log[n0+6]), 144'(2'b01));
    chk("t1_data", 144'(rd_log[n0+6]), 144'(48'd804));

    // sign and carry handling via req1
    n0 = ncyc; set_op(1, 18'h3FFFF, 4'b1111); req_valid = 2'b10;
    tick(); req_valid = '0;
    ticks(12);
    chk("t2_valid", 144'(rv_log[n0+6]), 144'(2'b10));
    chk("t2_data", 144'(rd_log[n0+6]), 144'(48'hFFFF_FFFF_FFFC));

    // contention: both requesters every cycle
    n0 = ncyc; req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin rand_ops(); tick(); end
    req_valid = '0;
    ticks(12);
    for (int k = 0; k < 8; k++) begin
      chk("t3_grant", 144'(rr_log[n0+k]), 144'((k % 2) ? 2'b10 : 2'b01));
      chk("t3_result", 144'(rv_log[n0+6+k]), 144'((k % 2) ? 2'b10 : 2'b01));
    end

    // bubbles: req0 valid every other cycle
    n0 = ncyc;
    for (int k = 0; k < 6; k++) begin
      rand_ops(); req_valid = (k % 2 == 0) ? 2'b01 : 2'b00; tick();
    end
    req_valid = '0;
    ticks(12);
    for (int k = 1; k <= 6; k++)
      chk("t4_dsp_reset", 144'(dr_log[n0+k]), 144'((k % 2 == 0) ? 1 : 0));
    for (int k = 6; k <= 10; k++)
      chk("t4_result", 144'(rv_log[n0+k]), 144'((k % 2 == 0) ? 2'b01 : 2'b00));

    // flush two cycles into a three-op burst
    n0 = ncyc; rand_ops(); req_valid = 2'b01;
    tick(); rand_ops();
    tick(); flush = 1'b1;
    tick(); req_valid = '0;
    ticks(12);
    flush = 1'b0;
    tick();
    ticks(4);
    chk("t5_no_grant", 144'(rr_log[n0+2]), 144'(0));
    chk("t5_res0", 144'(rv_log[n0+6]), 144'(2'b01));
    chk("t5_res1", 144'(rv_log[n0+7]), 144'(2'b01));
    chk("t5_no_res2", 144'(rv_log[n0+8]), 144'(0));
    chk("t5_fd_low", 144'(fd_log[n0+7]), 144'(0));
    chk("t5_fd_rise", 144'(fd_log[n0+8]), 144'(1));
    chk("t5_fd_held", 144'(fd_log[n0+15]), 144'(1));
    chk("t5_fd_clear", 144'(fd_log[n0+16]), 144'(0));

    // reset with four ops in flight
    n0 = ncyc; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin rand_ops(); tick(); end
    aresetn = 1'b0;
    tick(); aresetn = 1'b1; req_valid = '0;
    ticks(7);
    rand_ops(); req_valid = 2'b11;
    tick(); req_valid = '0;
    ticks(10);
    chk("t6_rst_ready", 144'(rr_log[n0+4]), 144'(0));
    for (int k = 5; k <= 12; k++) chk("t6_no_result", 144'(rv_log[n0+k]), 144'(0));
    chk("t6_first_grant", 144'(rr_log[n0+12]), 144'(2'b01));
    chk("t6_new_result", 144'(rv_log[n0+18]), 144'(2'b01));

    // randomized traffic with occasional flush
    for (int k = 0; k < 1500; k++) begin
      rand_ops();
      req_valid = NR'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) flush = ~flush;
      tick();
    end
    req_valid = '0; flush = 1'b0;
    ticks(12);
    chk("end_busy", 144'(busy), 144'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
